// File: rtl/ceyloniac_pkg.sv
// Shared encodings and width for the Ceyloniac execute stage.
// The ALU output register and the multiply/divide unit both size off ALU_WIDTH.
package ceyloniac_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        MULU_LO = 2'b00,
        MULU_HI = 2'b01,
        DIVU_Q  = 2'b10,
        DIVU_R  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

endpackage

// File: rtl/ceyloniac_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; the caller owns the accumulator registers.
module ceyloniac_muldiv_step #(
    parameter int W = 32
) (
    input  logic         div_mode,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next
);

    logic [W:0]   sum;
    logic [W:0]   r_sh;
    logic [W-1:0] diff;
    logic         fits;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        // The stored remainder is always below B, so only the shifted
        // value needs the extra bit.
        r_sh = {hi, lo[W-1]};
        fits = (r_sh >= {1'b0, b});
        diff = r_sh[W-1:0] - b;
        if (!div_mode) begin
            hi_next = sum[W:1];
            lo_next = {sum[0], lo[W-1:1]};
        end else if (fits) begin
            hi_next = diff;
            lo_next = {lo[W-2:0], 1'b1};
        end else begin
            hi_next = r_sh[W-1:0];
            lo_next = {lo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ceyloniac_muldiv_unit.sv
// Iterative unsigned multiply/divide, one bit per clock, start/busy/done handshake.
// Result and divide-by-zero status hold until the next completion.
module ceyloniac_muldiv_unit
    import ceyloniac_pkg::*;
#(
    parameter int ALU_DATA_WIDTH = ALU_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [ALU_DATA_WIDTH-1:0] operand_a,
    input  logic [ALU_DATA_WIDTH-1:0] operand_b,
    output logic                      busy,
    output logic                      done,
    output logic [ALU_DATA_WIDTH-1:0] result,
    output logic                      div_by_zero
);

    localparam int W     = ALU_DATA_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;

    muldiv_state_t state, next_state;
    muldiv_op_t    op_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_hi, acc_lo;
    logic [W-1:0]  step_hi, step_lo;
    logic [W-1:0]  result_next;
    logic [CNT_W-1:0] cnt;
    logic          accept, last_step, div_zero_now, finish;

    ceyloniac_muldiv_step #(.W(W)) u_step (
        .div_mode (op_q[1]),
        .hi       (acc_hi),
        .lo       (acc_lo),
        .b        (b_q),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        accept       = start && (state == ST_IDLE || state == ST_DONE);
        last_step    = (cnt == CNT_W'(W - 1));
        div_zero_now = (state == ST_DIV) && (b_q == '0);
        next_state   = state;
        case (state)
            ST_IDLE: if (start) next_state = op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (last_step) next_state = ST_DONE;
            ST_DIV:  if (div_zero_now || last_step) next_state = ST_DONE;
            ST_DONE: next_state = start ? (op[1] ? ST_DIV : ST_MUL) : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_MUL) || (state == ST_DIV);
        done   = (state == ST_DONE);
        finish = busy && (next_state == ST_DONE);
    end

    always_comb begin
        result_next = step_hi;
        if (div_zero_now)
            result_next = (op_q == DIVU_Q) ? '1 : acc_lo;
        else if (op_q == MULU_LO || op_q == DIVU_Q)
            result_next = step_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= MULU_LO;
            b_q         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q   <= muldiv_op_t'(op);
            b_q    <= operand_b;
            acc_hi <= '0;
            acc_lo <= operand_a;
            cnt    <= '0;
        end else if (busy) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (finish) begin
                result      <= result_next;
                div_by_zero <= div_zero_now;
            end
        end
    end

endmodule
